// File: rtl/ogege_pkg.sv
// Shared display geometry and fetch-FSM encoding for the ogege video path.
package ogege_pkg;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int CANVAS_W  = 320;
    localparam int CANVAS_H  = 240;

    localparam logic [1:0] FETCH_IDLE = 2'd0;
    localparam logic [1:0] FETCH_REQ  = 2'd1;
    localparam logic [1:0] FETCH_WAIT = 2'd2;
    localparam logic [1:0] FETCH_NEXT = 2'd3;

endpackage

// File: rtl/line_ram.sv
// Two-bank line buffer: one write port, one registered read port.
// The bank bit selects the upper half of the array (entries WORDS..2*WORDS-1).
module line_ram #(
    parameter int WORDS = 320,
    parameter int DW    = 12,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk_100mhz,
    input  logic          we_i,
    input  logic          wbank_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic          rbank_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2*WORDS];
    logic [DW-1:0] rdata_q;
    logic [AW:0]   wa;
    logic [AW:0]   ra;

    assign wa = wbank_i ? (AW+1)'(WORDS) + {1'b0, waddr_i} : {1'b0, waddr_i};
    assign ra = rbank_i ? (AW+1)'(WORDS) + {1'b0, raddr_i} : {1'b0, raddr_i};

    // Read-before-write: a same-address read returns the old word.
    always_ff @(posedge clk_100mhz) begin
        if (we_i) begin
            mem_q[wa] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[ra];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/scanline_fetcher.sv
// Fetches canvas rows from PSRAM into a ping-pong line buffer one row ahead of
// the scan, and serves pixel colours from the bank currently on display.
module scanline_fetcher #(
    parameter int CANVAS_W      = ogege_pkg::CANVAS_W,
    parameter int CANVAS_H      = ogege_pkg::CANVAS_H,
    parameter int PREFETCH_LINE = 480
) (
    input  logic        clk_100mhz,
    input  logic        rstn_i,
    input  logic        i_pix_en,
    input  logic [9:0]  i_h_count,
    input  logic [8:0]  i_v_count,
    input  logic        i_active,
    input  logic [23:0] i_base_addr,
    output logic        o_psram_stb,
    output logic        o_psram_we,
    output logic [23:0] o_psram_addr,
    input  logic        i_psram_busy,
    input  logic        i_psram_done,
    input  logic [15:0] i_psram_dout,
    output logic [11:0] o_color,
    output logic        o_underrun,
    output logic [1:0]  o_state
);

    import ogege_pkg::H_VISIBLE;
    import ogege_pkg::V_VISIBLE;
    import ogege_pkg::FETCH_IDLE;
    import ogege_pkg::FETCH_REQ;
    import ogege_pkg::FETCH_WAIT;

    localparam int IW = $clog2(CANVAS_W);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [23:0]   cnt_q, cnt_d;
    logic          bank_q, bank_d;
    logic          underrun_q, underrun_d;
    logic          pend_q, pend_d;
    logic          pend_load_q, pend_load_d;
    logic          pend_bank_q, pend_bank_d;
    logic [23:0]   pend_base_q, pend_base_d;
    logic          vis_q;
    logic [11:0]   color_q;

    logic [7:0]    row;
    logic          line_end, frame_trig, row_trig, trig, trig_bank, abort;
    logic          ram_we, ram_re, in_range;
    logic [11:0]   ram_rdata;
    logic          dout_unused;

    assign row        = i_v_count[8:1];
    assign line_end   = i_pix_en && (i_h_count == 10'(H_VISIBLE));
    assign frame_trig = line_end && (i_v_count == 9'(PREFETCH_LINE));
    assign row_trig   = line_end && (i_v_count < 9'(V_VISIBLE)) && !i_v_count[0]
                        && ({1'b0, row} < 9'(CANVAS_H - 1));
    assign trig       = frame_trig || row_trig;
    assign trig_bank  = frame_trig ? 1'b0 : ~row[0];
    // A pending or fresh trigger means the running fetch is being abandoned.
    assign abort      = trig || pend_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        bank_d      = bank_q;
        underrun_d  = underrun_q;
        pend_d      = pend_q;
        pend_load_d = pend_load_q;
        pend_bank_d = pend_bank_q;
        pend_base_d = pend_base_q;
        ram_we      = 1'b0;

        if (trig && state_q != FETCH_IDLE) begin
            underrun_d  = 1'b1;
            pend_d      = 1'b1;
            pend_load_d = frame_trig;
            pend_bank_d = trig_bank;
            pend_base_d = i_base_addr;
        end

        case (state_q)
            FETCH_IDLE: begin
                if (trig || pend_q) begin
                    state_d = FETCH_REQ;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    bank_d  = trig ? trig_bank : pend_bank_q;
                    if (trig ? frame_trig : pend_load_q) begin
                        cnt_d = trig ? i_base_addr : pend_base_q;
                    end
                end
            end
            FETCH_REQ: begin
                if (i_psram_busy) begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                // An in-flight read must finish before we let go; its data is dropped on abort.
                if (i_psram_done) begin
                    if (abort) begin
                        state_d = FETCH_IDLE;
                    end else begin
                        ram_we  = 1'b1;
                        state_d = ogege_pkg::FETCH_NEXT;
                    end
                end
            end
            default: begin
                cnt_d = cnt_q + 24'd1;
                idx_d = idx_q + IW'(1);
                if (abort || idx_q == IW'(CANVAS_W - 1)) begin
                    state_d = FETCH_IDLE;
                end else if (!i_psram_busy) begin
                    state_d = FETCH_REQ;
                end
            end
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= FETCH_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            bank_q      <= 1'b0;
            underrun_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_load_q <= 1'b0;
            pend_bank_q <= 1'b0;
            pend_base_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            bank_q      <= bank_d;
            underrun_q  <= underrun_d;
            pend_q      <= pend_d;
            pend_load_q <= pend_load_d;
            pend_bank_q <= pend_bank_d;
            pend_base_q <= pend_base_d;
        end
    end

    assign in_range = {1'b0, i_h_count[9:1]} < 10'(CANVAS_W);
    assign ram_re   = i_pix_en && in_range;

    line_ram #(
        .WORDS (CANVAS_W),
        .DW    (12)
    ) u_line_ram (
        .clk_100mhz (clk_100mhz),
        .we_i       (ram_we),
        .wbank_i    (bank_q),
        .waddr_i    (idx_q),
        .wdata_i    (i_psram_dout[11:0]),
        .re_i       (ram_re),
        .rbank_i    (row[0]),
        .raddr_i    (IW'(i_h_count[9:1])),
        .rdata_o    (ram_rdata)
    );

    // The RAM word read on one strobe is presented on the next strobe.
    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            vis_q   <= 1'b0;
            color_q <= 12'h000;
        end else if (i_pix_en) begin
            color_q <= vis_q ? ram_rdata : 12'h000;
            vis_q   <= i_active && in_range;
        end
    end

    assign dout_unused  = &{1'b0, i_psram_dout[15:12], i_h_count[0]};

    assign o_psram_stb  = (state_q == FETCH_REQ);
    assign o_psram_we   = 1'b0;
    assign o_psram_addr = cnt_q;
    assign o_color      = color_q;
    assign o_underrun   = underrun_q;
    assign o_state      = state_q;

endmodule
